uart_tx_cfg: RTL and testbench

Configurable, buffered UART transmitter: the next generation of the fixed-format transmitter in the peripheral bus. It accepts bytes through a valid/ready push port into an internal FIFO and serialises them on `tx` with a runtime-selectable baud divisor, data length (5–8), parity (none/even/odd) and stop bits (1/2). It sits between the memory-mapped UART register block and the board TX pin. Software can queue several bytes without polling per character.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_tx_cfg_if.sv | 11 +
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_tx_cfg.sv | 141 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: parity codes, FSM states, frame config.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Per-frame settings captured when a byte leaves the FIFO
    typedef struct packed {
        logic [3:0] nbits;
        logic       par_en;
        logic       stop2;
    } frame_cfg_t;

    function automatic logic [3:0] bits_len(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

    function automatic logic data_parity(input logic [7:0] dat, input logic [3:0] nbits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits)) p = p ^ dat[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte push port into the transmitter FIFO.
// Latency: word captured on the edge where in_valid && in_ready.
// Backpressure: in_ready low while the FIFO is full.
interface uart_tx_cfg_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with occupancy count.
// Latency: head visible on rd_dat the cycle after a push into an empty FIFO.
// Backpressure: full asserted at DEPTH entries; caller must not push when full or pop when empty.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_dat,
    input  logic                     pop,
    output logic [W-1:0]             rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign full   = (level_q == (AW+1)'(DEPTH));
    assign empty  = (level_q == '0);
    assign level  = level_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with runtime divisor, length, parity and stop-bit selection.
// Latency: push into an empty idle block drives the start bit from the following edge.
// Backpressure: in_ready = !full; frames stream back-to-back while the FIFO holds data.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CD_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CD_WIDTH-1:0]      cfg_div,
    input  logic [1:0]               cfg_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    uart_tx_cfg_if.slave             in_if,
    output logic                     tx,
    output logic                     busy,
    output logic                     tx_done,
    output logic [$clog2(DEPTH):0]   level
);
    logic       fifo_full, fifo_empty, push, pop, load, bit_end;
    logic [7:0] fifo_dat;

    state_e              state_q, state_d;
    logic [CD_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
    frame_cfg_t          cfg_q, cfg_d;
    logic [7:0]          sh_q, sh_d;
    logic [3:0]          idx_q, idx_d;
    logic                par_q, par_d, tx_q, tx_d, done_q, done_d;

    assign push           = in_if.in_valid && !fifo_full;
    assign in_if.in_ready = !fifo_full;

    uart_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push),
        .wr_dat (in_if.in_data),
        .pop    (pop),
        .rd_dat (fifo_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign bit_end = (cnt_q == div_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CD_WIDTH'(1);
        div_d   = div_q;
        cfg_d   = cfg_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                load  = !fifo_empty;
            end
            ST_START: if (bit_end) begin
                state_d = ST_DATA;
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
                idx_d   = '0;
            end
            ST_DATA: if (bit_end) begin
                if (idx_q == cfg_q.nbits - 4'd1) begin
                    idx_d   = '0;
                    state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
                    tx_d    = cfg_q.par_en ? par_q : 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
            end
            ST_STOP: if (bit_end) begin
                if (cfg_q.stop2 && idx_q == 4'd0) begin
                    idx_d = 4'd1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    load    = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Config is sampled only here so mid-frame changes wait for the next frame
        if (load) begin
            state_d      = ST_START;
            tx_d         = 1'b0;
            cnt_d        = '0;
            sh_d         = fifo_dat;
            div_d        = cfg_div;
            cfg_d.nbits  = bits_len(cfg_bits);
            cfg_d.par_en = (parity_e'(cfg_parity) == PAR_EVEN) || (parity_e'(cfg_parity) == PAR_ODD);
            cfg_d.stop2  = cfg_stop2;
            par_d        = data_parity(fifo_dat, bits_len(cfg_bits)) ^ (parity_e'(cfg_parity) == PAR_ODD);
        end
        pop = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            cfg_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            cfg_q   <= cfg_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_done = done_q;
    assign busy    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: line monitor decodes every frame against a queue of expected frames.
module tb_uart_tx_cfg;
    localparam int DEPTH = 4;
    localparam int CDW   = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [CDW-1:0] cfg_div = '0;
    logic [1:0]     cfg_bits = 2'd3;
    logic [1:0]     cfg_parity = 2'd0;
    logic           cfg_stop2 = 1'b0;
    logic           tx, busy, tx_done;
    logic [2:0]     level;

    uart_tx_cfg_if in_if();

    uart_tx_cfg #(.DEPTH(DEPTH), .CD_WIDTH(CDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_div    (cfg_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .in_if      (in_if),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dat;
        int         nbits;
        int         par;
        bit         stop2;
        int         div;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   done_pulses = 0;

    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) if (rst_n && tx_done === 1'b1) done_pulses++;

    function automatic exp_t mk_exp(input logic [7:0] d, input int bits_code, input int par,
                                    input bit s2, input int div);
        exp_t e;
        e.dat = d; e.nbits = 5 + bits_code; e.par = par; e.stop2 = s2; e.div = div;
        return e;
    endfunction

    // Serial line monitor: expands the expected frame into per-bit levels and checks every cycle
    exp_t cur;
    logic fseq [0:11];
    int   flen, fcyc, bad;
    bit   in_frame = 0, pend_done = 0, unexp_seen = 0;
    logic p;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 0;
            pend_done = 0;
        end else begin
            if (pend_done) begin
                pend_done = 0;
                checks++;
                if (tx_done !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_done_after_frame got %b want 1 (cycle %0d)", tx_done, cyc_cnt);
                end
            end
            if (!in_frame && tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    if (!unexp_seen) begin
                        unexp_seen = 1;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame start at cycle %0d with empty scoreboard", cyc_cnt);
                    end
                end else begin
                    cur  = sb_q.pop_front();
                    flen = 0;
                    fseq[flen] = 1'b0; flen = flen + 1;
                    p = 1'b0;
                    for (int i = 0; i < cur.nbits; i++) begin
                        fseq[flen] = cur.dat[i]; flen = flen + 1;
                        p = p ^ cur.dat[i];
                    end
                    if (cur.par == 1 || cur.par == 2) begin
                        fseq[flen] = (cur.par == 2) ? ~p : p; flen = flen + 1;
                    end
                    fseq[flen] = 1'b1; flen = flen + 1;
                    if (cur.stop2) begin fseq[flen] = 1'b1; flen = flen + 1; end
                    fcyc = 0;
                    bad  = 0;
                    in_frame = 1;
                end
            end
            if (in_frame) begin
                if (tx !== fseq[fcyc / (cur.div + 1)]) bad++;
                if (fcyc != 0 && tx_done !== 1'b0) bad++;
                fcyc++;
                if (fcyc == flen * (cur.div + 1)) begin
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame_0x%02h bad_cycles got %0d want 0", cur.dat, bad);
                    end
                    in_frame  = 0;
                    pend_done = 1;
                end
            end
        end
    end

    task automatic set_cfg(input int div, input int bits, input int par, input bit s2);
        @(negedge clk);
        cfg_div = CDW'(div); cfg_bits = 2'(bits); cfg_parity = 2'(par); cfg_stop2 = s2;
    endtask

    task automatic push_byte(input logic [7:0] d, input exp_t e, output int k);
        @(negedge clk);
        checks++;
        if (in_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready got %b want 1", in_if.in_ready);
        end
        in_if.in_data  = d;
        in_if.in_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        k = cyc_cnt;
        in_if.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                c = cyc_cnt;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting tx_done after %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 5;
        if (tx !== 1'b1)             begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (tx_done !== 1'b0)        begin errors++; $display("FAIL reset_tx_done got %b want 0", tx_done); end
        if (level !== 3'd0)          begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        if (in_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_if.in_ready); end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input int div, input int bits,
                              input int par, input bit s2, input int exp_len);
        int k, c;
        set_cfg(div, bits, par, s2);
        done_pulses = 0;
        push_byte(d, mk_exp(d, bits, par, s2, div), k);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL %s tx_before_pop got %b want 1", name, tx); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL %s start_bit got %b want 0", name, tx); end
        wait_done(name, exp_len + 20, c);
        checks += 2;
        if (c != k + 1 + exp_len) begin
            errors++;
            $display("FAIL %s frame_len got %0d want %0d", name, c - k - 1, exp_len);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
        repeat (3) @(negedge clk);
        checks++;
        if (done_pulses != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_pulses); end
    endtask

    task automatic test_fill();
        int accepted, first_k, last_c, seen;
        bit acc;
        set_cfg(100, 3, 0, 0);
        done_pulses = 0;
        accepted = 0;
        first_k  = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_if.in_data  = 8'(8'h10 + i);
            in_if.in_valid = 1'b1;
            acc = (in_if.in_ready === 1'b1);
            if (acc) sb_q.push_back(mk_exp(8'(8'h10 + i), 3, 0, 0, 100));
            @(posedge clk);
            #1;
            if (acc) begin
                accepted++;
                if (first_k < 0) first_k = cyc_cnt;
            end
        end
        in_if.in_valid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (accepted != 5)           begin errors++; $display("FAIL fill_accepted got %0d want 5", accepted); end
        if (level !== 3'd4)          begin errors++; $display("FAIL fill_level got %0d want 4", level); end
        if (in_if.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", in_if.in_ready); end
        seen   = 0;
        last_c = -1;
        for (int i = 0; i < 6000 && seen < 5; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) begin seen++; last_c = cyc_cnt; end
        end
        checks += 2;
        if (seen != 5) begin errors++; $display("FAIL fill_done_seen got %0d want 5", seen); end
        if (last_c != first_k + 1 + 5 * 1010) begin
            errors++;
            $display("FAIL fill_total_len got %0d want %0d", last_c - first_k - 1, 5 * 1010);
        end
        repeat (3) @(negedge clk);
        checks += 2;
        if (done_pulses != 5) begin errors++; $display("FAIL fill_done_pulses got %0d want 5", done_pulses); end
        if (busy !== 1'b0)    begin errors++; $display("FAIL fill_busy_after got %b want 0", busy); end
    endtask

    task automatic test_cfg_change();
        int k, k2, c1, c2;
        set_cfg(3, 3, 0, 0);
        push_byte(8'hF0, mk_exp(8'hF0, 3, 0, 0, 3), k);
        push_byte(8'hE7, mk_exp(8'hE7, 0, 0, 0, 3), k2);
        repeat (10) @(negedge clk);
        cfg_bits = 2'd0;
        wait_done("cfg_change_first", 80, c1);
        wait_done("cfg_change_second", 80, c2);
        checks += 2;
        if (c1 != k + 41) begin errors++; $display("FAIL cfg_change_first_end got %0d want %0d", c1 - k, 41); end
        if (c2 != k + 69) begin errors++; $display("FAIL cfg_change_second_end got %0d want %0d", c2 - k, 69); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k, c;
        set_cfg(3, 3, 0, 0);
        push_byte(8'h00, mk_exp(8'h00, 3, 0, 0, 3), k);
        push_byte(8'h5A, mk_exp(8'h5A, 3, 0, 0, 3), k);
        repeat (9) @(posedge clk);
        #2;
        checks += 2;
        if (tx !== 1'b0)    begin errors++; $display("FAIL rmid_pre_tx got %b want 0", tx); end
        if (level !== 3'd1) begin errors++; $display("FAIL rmid_pre_level got %0d want 1", level); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (tx !== 1'b1)     begin errors++; $display("FAIL rmid_tx got %b want 1", tx); end
        if (level !== 3'd0)  begin errors++; $display("FAIL rmid_level got %0d want 0", level); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_byte(8'h3C, mk_exp(8'h3C, 3, 0, 0, 3), k);
        wait_done("rmid_clean", 80, c);
        checks++;
        if (c != k + 41) begin errors++; $display("FAIL rmid_clean_len got %0d want 41", c - k); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        test_reset();
        test_frame("8n1_55", 8'h55, 3, 3, 0, 1'b0, 40);
        test_frame("8e2_a3", 8'hA3, 3, 3, 1, 1'b1, 48);
        test_frame("7o1_c1", 8'hC1, 0, 2, 2, 1'b0, 10);
        test_fill();
        test_cfg_change();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
